// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_pkg: shared types, ASCII codes and keyword tables for the UART
// command controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MATCH  = 3'd1,
        ST_DIGITS = 3'd2,
        ST_EXEC   = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_CLEAR = 2'd1,
        CMD_MODE  = 2'd2,
        CMD_SETHZ = 2'd3
    } cmd_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;

    // Keywords are left-justified in 40 bits so character i is always byte i.
    localparam logic [39:0] KW_RUN   = {"run", 16'h0000};
    localparam logic [39:0] KW_CLEAR = "clear";
    localparam logic [39:0] KW_MODE  = {"mode", 8'h00};
    localparam logic [39:0] KW_SETHZ = "sethz";

    localparam logic [2:0] KW_RUN_LEN   = 3'd3;
    localparam logic [2:0] KW_CLEAR_LEN = 3'd5;
    localparam logic [2:0] KW_MODE_LEN  = 3'd4;
    localparam logic [2:0] KW_SETHZ_LEN = 3'd5;

    function automatic logic [7:0] kw_char(input cmd_e c, input logic [2:0] i);
        logic [39:0] kw;
        case (c)
            CMD_RUN:   kw = KW_RUN;
            CMD_CLEAR: kw = KW_CLEAR;
            CMD_MODE:  kw = KW_MODE;
            default:   kw = KW_SETHZ;
        endcase
        case (i)
            3'd0:    kw_char = kw[39:32];
            3'd1:    kw_char = kw[31:24];
            3'd2:    kw_char = kw[23:16];
            3'd3:    kw_char = kw[15:8];
            default: kw_char = kw[7:0];
        endcase
    endfunction

    function automatic logic [2:0] kw_last(input cmd_e c);
        case (c)
            CMD_RUN:   kw_last = KW_RUN_LEN - 3'd1;
            CMD_CLEAR: kw_last = KW_CLEAR_LEN - 3'd1;
            CMD_MODE:  kw_last = KW_MODE_LEN - 3'd1;
            default:   kw_last = KW_SETHZ_LEN - 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmd_timeout_cnt: inter-character timeout; expired fires in the cycle the
// count of enabled cycles reaches TIMEOUT_CLKS.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cmd_timeout_cnt #(
    parameter int unsigned TIMEOUT_CLKS = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0]  CNT_END = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q;

    assign expired = en && (cnt_q == CNT_END);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_ctrl: parses ASCII commands from an RX FIFO, drives counter control
// pulses and acknowledges each command with 'K' or 'E' into a TX FIFO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CLKS = 10_000_000,
    parameter int unsigned MAX_HZ       = 100_000,
    parameter int unsigned DEF_HZ       = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  rx_rdata,
    output logic        rx_pop,
    input  logic        tx_full,
    output logic        tx_push,
    output logic [7:0]  tx_wdata,
    output logic        cmd_run,
    output logic        cmd_clear,
    output logic        cmd_mode,
    output logic [16:0] hz_value,
    output logic        hz_load,
    output logic        busy
);

    import uart_cmd_pkg::*;

    localparam logic [19:0] MAX_ACC  = 20'(MAX_HZ);
    localparam logic [16:0] HZ_RESET = 17'(DEF_HZ);

    state_e      state_q;
    cmd_e        cmd_q;
    logic [2:0]  idx_q;
    logic [19:0] acc_q;
    logic [2:0]  ndig_q;
    logic [7:0]  tx_wdata_q;
    logic        cmd_run_q;
    logic        cmd_clear_q;
    logic        cmd_mode_q;
    logic [16:0] hz_value_q;
    logic        hz_load_q;

    logic        in_parse;
    logic        is_digit;
    logic        is_blank;
    logic [19:0] acc_d;
    logic        to_expired;

    assign in_parse = (state_q == ST_MATCH) || (state_q == ST_DIGITS);
    assign is_digit = (rx_rdata >= ASCII_ZERO) && (rx_rdata <= ASCII_NINE);
    assign is_blank = (rx_rdata == ASCII_CR) || (rx_rdata == ASCII_LF) || (rx_rdata == ASCII_SP);
    assign acc_d    = (acc_q * 20'd10) + {12'd0, (rx_rdata - ASCII_ZERO)};

    // Pop and push depend on the live FIFO flags so each byte is consumed in
    // the same cycle it is examined and the ack goes out as soon as space frees.
    assign rx_pop  = !rst && !rx_empty &&
                     ((state_q == ST_IDLE) || in_parse);
    assign tx_push = !rst && !tx_full && (state_q == ST_ACK);
    assign busy    = (state_q != ST_IDLE);

    assign tx_wdata  = tx_wdata_q;
    assign cmd_run   = cmd_run_q;
    assign cmd_clear = cmd_clear_q;
    assign cmd_mode  = cmd_mode_q;
    assign hz_value  = hz_value_q;
    assign hz_load   = hz_load_q;

    cmd_timeout_cnt #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_pop || !in_parse),
        .en      (in_parse && rx_empty),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_RUN;
            idx_q       <= 3'd0;
            acc_q       <= 20'd0;
            ndig_q      <= 3'd0;
            tx_wdata_q  <= 8'd0;
            cmd_run_q   <= 1'b0;
            cmd_clear_q <= 1'b0;
            cmd_mode_q  <= 1'b0;
            hz_value_q  <= HZ_RESET;
            hz_load_q   <= 1'b0;
        end else begin
            cmd_run_q   <= 1'b0;
            cmd_clear_q <= 1'b0;
            cmd_mode_q  <= 1'b0;
            hz_load_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        if (rx_rdata == KW_RUN[39:32]) begin
                            cmd_q   <= CMD_RUN;
                            idx_q   <= 3'd1;
                            state_q <= ST_MATCH;
                        end else if (rx_rdata == KW_CLEAR[39:32]) begin
                            cmd_q   <= CMD_CLEAR;
                            idx_q   <= 3'd1;
                            state_q <= ST_MATCH;
                        end else if (rx_rdata == KW_MODE[39:32]) begin
                            cmd_q   <= CMD_MODE;
                            idx_q   <= 3'd1;
                            state_q <= ST_MATCH;
                        end else if (rx_rdata == KW_SETHZ[39:32]) begin
                            cmd_q   <= CMD_SETHZ;
                            idx_q   <= 3'd1;
                            state_q <= ST_MATCH;
                        end else if (!is_blank) begin
                            tx_wdata_q <= ASCII_E;
                            state_q    <= ST_ACK;
                        end
                    end
                end

                ST_MATCH: begin
                    if (to_expired) begin
                        tx_wdata_q <= ASCII_E;
                        state_q    <= ST_ACK;
                    end else if (!rx_empty) begin
                        if (rx_rdata != kw_char(cmd_q, idx_q)) begin
                            tx_wdata_q <= ASCII_E;
                            state_q    <= ST_ACK;
                        end else if (idx_q != kw_last(cmd_q)) begin
                            idx_q <= idx_q + 3'd1;
                        end else if (cmd_q == CMD_SETHZ) begin
                            acc_q   <= 20'd0;
                            ndig_q  <= 3'd0;
                            state_q <= ST_DIGITS;
                        end else begin
                            cmd_run_q   <= (cmd_q == CMD_RUN);
                            cmd_clear_q <= (cmd_q == CMD_CLEAR);
                            cmd_mode_q  <= (cmd_q == CMD_MODE);
                            state_q     <= ST_EXEC;
                        end
                    end
                end

                ST_DIGITS: begin
                    if (to_expired) begin
                        tx_wdata_q <= ASCII_E;
                        state_q    <= ST_ACK;
                    end else if (!rx_empty) begin
                        if (is_digit) begin
                            if (ndig_q == 3'd6) begin
                                tx_wdata_q <= ASCII_E;
                                state_q    <= ST_ACK;
                            end else begin
                                acc_q  <= acc_d;
                                ndig_q <= ndig_q + 3'd1;
                            end
                        end else if (rx_rdata == ASCII_COLON) begin
                            if ((ndig_q == 3'd0) || (acc_q == 20'd0) || (acc_q > MAX_ACC)) begin
                                tx_wdata_q <= ASCII_E;
                                state_q    <= ST_ACK;
                            end else begin
                                hz_value_q <= acc_q[16:0];
                                hz_load_q  <= 1'b1;
                                state_q    <= ST_EXEC;
                            end
                        end else begin
                            tx_wdata_q <= ASCII_E;
                            state_q    <= ST_ACK;
                        end
                    end
                end

                ST_EXEC: begin
                    tx_wdata_q <= ASCII_K;
                    state_q    <= ST_ACK;
                end

                ST_ACK: begin
                    if (!tx_full) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_cmd_ctrl: directed scenarios against a queue-modelled RX FIFO and a
// log of bytes pushed into the TX FIFO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_empty;
    logic [7:0]  rx_rdata;
    logic        rx_pop;
    logic        tx_full;
    logic        tx_push;
    logic [7:0]  tx_wdata;
    logic        cmd_run;
    logic        cmd_clear;
    logic        cmd_mode;
    logic [16:0] hz_value;
    logic        hz_load;
    logic        busy;

    uart_cmd_ctrl #(
        .TIMEOUT_CLKS (50),
        .MAX_HZ       (100_000),
        .DEF_HZ       (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .rx_rdata  (rx_rdata),
        .rx_pop    (rx_pop),
        .tx_full   (tx_full),
        .tx_push   (tx_push),
        .tx_wdata  (tx_wdata),
        .cmd_run   (cmd_run),
        .cmd_clear (cmd_clear),
        .cmd_mode  (cmd_mode),
        .hz_value  (hz_value),
        .hz_load   (hz_load),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] rxq[$];
    logic [7:0] tx_log[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int push_cyc = 0;
    int clear_cyc = 0;
    int mode_cyc = 0;
    int lat = -1;
    int n_run = 0;
    int n_clear = 0;
    int n_mode = 0;
    int n_load = 0;
    int n_multi = 0;
    logic s_busy = 1'b0;
    logic s_pop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] txb(input int i);
        if (i < tx_log.size()) return 32'(tx_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic update_rx();
        rx_empty = (rxq.size() == 0);
        rx_rdata = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
        update_rx();
    endtask

    task automatic clr_log();
        tx_log.delete();
        n_run = 0; n_clear = 0; n_mode = 0; n_load = 0; lat = -1;
    endtask

    // Outputs sampled on the falling edge; FIFO model and inputs updated 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        s_pop  = rx_pop;
        s_busy = busy;
        if (tx_push) begin
            tx_log.push_back(tx_wdata);
            push_cyc = cyc;
        end
        if (cmd_run)   begin n_run++;   lat = cyc - pop_cyc; end
        if (cmd_clear) begin n_clear++; lat = cyc - pop_cyc; clear_cyc = cyc; end
        if (cmd_mode)  begin n_mode++;  lat = cyc - pop_cyc; mode_cyc = cyc; end
        if (hz_load)   begin n_load++;  lat = cyc - pop_cyc; end
        if ((int'(cmd_run) + int'(cmd_clear) + int'(cmd_mode) + int'(hz_load)) > 1) n_multi++;
        if (s_pop) pop_cyc = cyc;
        @(posedge clk);
        #1;
        if (s_pop && rxq.size() > 0) void'(rxq.pop_front());
        cyc++;
        update_rx();
    endtask

    task automatic run_idle(input string tag);
        int n = 0;
        step();
        while (!(rxq.size() == 0 && !s_busy && !s_pop) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check({tag, "_idle_timeout"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tx_full = 1'b0;
        update_rx();
        feed("r");
        repeat (3) step();
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_hz",       32'(hz_value), 32'd100);
        check("rst_wdata",    32'(tx_wdata), 32'd0);
        check("rst_pop",      32'(rx_pop),   32'd0);
        check("rst_push",     32'(tx_push),  32'd0);
        check("rst_pulses",   32'({cmd_run, cmd_clear, cmd_mode, hz_load}), 32'd0);
        rxq.delete();
        update_rx();
        rst = 1'b0;
        step();

        clr_log();
        feed("run");
        run_idle("run");
        check("run_pulses",  32'(n_run),      32'd1);
        check("run_latency", 32'(lat),        32'd1);
        check("run_acks",    32'(tx_log.size()), 32'd1);
        check("run_ack_K",   txb(0),          32'h4B);

        clr_log();
        feed("clearmode");
        run_idle("clrmode");
        check("cm_clear",  32'(n_clear), 32'd1);
        check("cm_mode",   32'(n_mode),  32'd1);
        check("cm_other",  32'(n_run + n_load), 32'd0);
        check("cm_order",  32'(clear_cyc < mode_cyc), 32'd1);
        check("cm_acks",   32'(tx_log.size()), 32'd2);
        check("cm_ack0",   txb(0), 32'h4B);
        check("cm_ack1",   txb(1), 32'h4B);

        clr_log();
        feed("sethz10000:");
        run_idle("hz10000");
        check("hz_value",   32'(hz_value), 32'd10000);
        check("hz_load",    32'(n_load),   32'd1);
        check("hz_latency", 32'(lat),      32'd1);
        check("hz_ack",     txb(0),        32'h4B);

        clr_log();
        feed("sethz100001:");
        run_idle("hzbig");
        check("hzbig_ack",  txb(0),        32'h45);
        check("hzbig_hold", 32'(hz_value), 32'd10000);
        check("hzbig_load", 32'(n_load),   32'd0);

        clr_log();
        feed("sethz:");
        run_idle("hznone");
        check("hznone_ack",  txb(0), 32'h45);
        check("hznone_acks", 32'(tx_log.size()), 32'd1);

        clr_log();
        feed("sethz0:");
        run_idle("hzzero");
        check("hzzero_ack", txb(0), 32'h45);

        clr_log();
        feed("sethz1234567:");
        run_idle("hz7dig");
        check("hz7_acks", 32'(tx_log.size()), 32'd2);
        check("hz7_ack0", txb(0), 32'h45);
        check("hz7_ack1", txb(1), 32'h45);
        check("hz7_hold", 32'(hz_value), 32'd10000);

        clr_log();
        feed("sethz100000:");
        run_idle("hzmax");
        check("hzmax_value", 32'(hz_value), 32'd100000);
        check("hzmax_ack",   txb(0), 32'h4B);

        clr_log();
        feed("rxn");
        run_idle("rxn");
        check("rxn_acks", 32'(tx_log.size()), 32'd2);
        check("rxn_ack0", txb(0), 32'h45);
        check("rxn_ack1", txb(1), 32'h45);
        check("rxn_run",  32'(n_run), 32'd0);

        clr_log();
        feed(" \r\nrun");
        run_idle("blank");
        check("blank_run", 32'(n_run), 32'd1);
        check("blank_acks", 32'(tx_log.size()), 32'd1);

        clr_log();
        tx_full = 1'b1;
        feed("moderun");
        repeat (20) step();
        check("full_mode",   32'(n_mode), 32'd1);
        check("full_nopush", 32'(tx_log.size()), 32'd0);
        check("full_nopop",  32'(rxq.size()), 32'd3);
        check("full_busy",   32'(s_busy), 32'd1);
        tx_full = 1'b0;
        run_idle("full");
        check("full_acks", 32'(tx_log.size()), 32'd2);
        check("full_ack0", txb(0), 32'h4B);
        check("full_ack1", txb(1), 32'h4B);
        check("full_run",  32'(n_run), 32'd1);

        // The ACK state is entered on the 50th edge after the 'e' pop edge, so the push is seen one cycle later.
        clr_log();
        feed("se");
        begin
            int n = 0;
            while (tx_log.size() == 0 && n < 200) begin
                step();
                n++;
            end
        end
        check("to_delay", 32'(push_cyc - pop_cyc), 32'd51);
        check("to_ack",   txb(0), 32'h45);
        run_idle("timeout");
        check("to_load",  32'(n_load), 32'd0);
        check("to_hz",    32'(hz_value), 32'd100000);

        clr_log();
        feed("seth");
        repeat (5) step();
        check("rstmid_busy_before", 32'(s_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_hz",   32'(hz_value), 32'd100);
        check("rstmid_busy", 32'(busy), 32'd0);
        repeat (60) step();
        check("rstmid_nopush", 32'(tx_log.size()), 32'd0);

        check("onehot_pulses", 32'(n_multi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 10_000_000; inter-character timeout in clk cycles (100 ms at 100 MHz).
REQ-002 Parameter MAX_HZ, default 100_000; largest legal sethz value.
REQ-003 Parameter DEF_HZ, default 100; hz_value after reset.
REQ-004 clk  input  1  system clock; the design uses this single clock only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_empty  input  1  RX FIFO empty flag.
REQ-007 rx_rdata  input  8  RX FIFO head byte (first-word-fall-through), valid while rx_empty=0.
REQ-008 rx_pop  output  1  one-cycle pulse that consumes the RX FIFO head byte.
REQ-009 tx_full  input  1  TX FIFO full flag.
REQ-010 tx_push  output  1  one-cycle push into the TX FIFO.
REQ-011 tx_wdata  output  8  byte pushed into the TX FIFO; valid with tx_push.
REQ-012 cmd_run  output  1  one-cycle pulse; toggles counter run/stop.
REQ-013 cmd_clear  output  1  one-cycle pulse; clears the counter.
REQ-014 cmd_mode  output  1  one-cycle pulse; toggles the up/down mode.
REQ-015 hz_value  output  17  counter tick frequency in Hz; held between updates.
REQ-016 hz_load  output  1  one-cycle pulse in the same cycle that hz_value is updated.
REQ-017 busy  output  1  high when the state is not IDLE.

Function
REQ-018 States: IDLE, MATCH, DIGITS, EXEC, ACK.
REQ-019 rx_pop is high only in IDLE, MATCH or DIGITS, and only when rx_empty=0; each pop processes rx_rdata in that same cycle.
REQ-020 IDLE byte handling:
- 'r', 'c', 'm' or 's': select keyword run, clear, mode or sethz respectively; set index=1; go to MATCH.
- CR, LF or space: discard silently.
- Any other byte: set error and go to ACK.
REQ-021 MATCH, byte equal to keyword[index]: index increments. On the final letter:
- run, clear, mode: go to EXEC.
- sethz: clear the accumulator and digit count; go to DIGITS.
REQ-022 MATCH, byte not equal to keyword[index]: discard the byte, set error, go to ACK; the byte is not re-parsed as a new command.
REQ-023 DIGITS:
- '0'..'9': acc = acc*10 + digit, using a 20-bit accumulator.
- ':': go to EXEC.
- Any other byte: set error, go to ACK.
REQ-024 A 7th digit sets error and goes to ACK.
REQ-025 On ':', set error and go to ACK if there are zero digits, acc=0, or acc>MAX_HZ.
REQ-026 EXEC lasts exactly one cycle and then goes to ACK.
- run, clear, mode: the matching cmd_* pulse is high for 1 cycle.
- sethz: hz_value<=acc[16:0] and hz_load=1.
REQ-027 Latency: from the pop of the final byte to the cmd_* or hz_load pulse is exactly 1 cycle.
REQ-028 ACK: tx_wdata = 'K' (0x4B) on success or 'E' (0x45) on error. tx_push is asserted in the first ACK cycle with tx_full=0, then the state goes to IDLE and the error flag clears. There are no pops while in ACK; bytes stay in the RX FIFO.
REQ-029 Timeout:
- The counter clears on every pop and on entry to MATCH or DIGITS.
- It counts while in MATCH or DIGITS with rx_empty=1.
- On reaching TIMEOUT_CLKS: set error, go to ACK, no command executes.
REQ-030 On error, hz_value is unchanged and no cmd_* pulse occurs.
REQ-031 At most one of cmd_run, cmd_clear, cmd_mode, hz_load is high in any cycle.

Reset
REQ-032 rst=1 forces all of the following on the next clk edge, including mid-command; the partial command is abandoned and no ack is sent:
- State IDLE.
- rx_pop, tx_push, cmd_*, hz_load, busy = 0.
- tx_wdata=0, hz_value=DEF_HZ.
- Accumulator, digit count, index and timeout counter = 0.

Structure
REQ-033 Package uart_cmd_pkg holds:
- The state enum.
- ASCII constants (CR, LF, space, ':', '0', '9', 'K', 'E').
- The keyword strings and their lengths (3, 5, 4, 5).
REQ-034 The timeout counter is a sub-module cmd_timeout_cnt (inputs: clr, en; output: expired); all other logic is one FSM.

Verification
REQ-035 Scenario: push "run" -> one cmd_run pulse 1 cycle after the 'n' pop; 'K' pushed.
REQ-036 Scenario: push "clear" then "mode" back-to-back -> cmd_clear then cmd_mode pulses; two 'K' pushes; no other pulses.
REQ-037 Scenario: push "sethz10000:" -> hz_value=10000 with hz_load; 'K'.
- "sethz100001:" -> 'E', hz_value stays 10000.
- "sethz:" -> 'E'.
REQ-038 Scenario: push "rxn" -> 'E' on the 'x'; 'n' then produces 'E' from IDLE; no cmd_run.
REQ-039 Scenario: hold tx_full=1 during an ack -> tx_push is deferred and rx_pop stays 0 until tx_full falls, then exactly one push.
REQ-040 Scenario: with TIMEOUT_CLKS=50, push "se" and stall -> 'E' 50 cycles after the 'e' pop. Separately, assert rst during "seth" -> hz_value=DEF_HZ, IDLE, no tx_push.
